regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared writeback definitions: register address width, default register count,
// the writeback request bundle, and the "does this rd really write" helper.
package rv_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int DEFAULT_NREGS = 16;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 and registers beyond the tracked file never reach the register file.
  function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd, input int nregs);
    return (rd != '0) && (int'(rd) < nregs);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer
// flips to the losing side after every grant and holds when idle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;  // 0 favours requester 0 (A), 1 favours requester 1 (B)

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (gnt != 2'b00)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto one register-file write port and
// tracks which registers have a claimed write still outstanding.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  claim_valid,
  input  logic [REG_ADDR_W-1:0] claim_rd,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_data,
  output logic [NREGS-1:0]      busy
);

  wb_req_t          a_req, b_req, win;
  logic [1:0]       gnt;
  logic             xfer;
  logic [NREGS-1:0] busy_q, busy_d;

  assign a_req = '{valid: a_valid, rd: a_rd, data: a_data};
  assign b_req = '{valid: b_valid, rd: b_rd, data: b_data};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign win     = gnt[1] ? b_req : a_req;
  assign xfer    = (gnt != 2'b00) && win.valid;
  assign busy    = busy_q;

  // Clear applies first so a same-edge claim of the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (rf_rd == REG_ADDR_W'(i))
        busy_d[i] = 1'b0;
      if (claim_valid && (claim_rd == REG_ADDR_W'(i)))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: rf_data is reset too, so the write port shows a known value straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd   <= '0;
      rf_data <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (xfer) begin
        rf_rd   <= rd_writable(win.rd, NREGS) ? win.rd : '0;
        rf_data <= win.data;
      end else begin
        rf_rd   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: the driver pushes hand-computed expectations tagged by cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, claim_valid;
  logic [4:0]  a_rd, b_rd, claim_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [15:0] busy;

  regfile_wb_arbiter #(.NREGS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .claim_valid (claim_valid),
    .claim_rd    (claim_rd),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          kind;   // 0: ready check, 1: write-port/busy check
    logic        ar, br;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [15:0] busy;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
      end else if (e.kind == 1'b0) begin
        check({e.nm, " a_ready"}, {31'b0, a_ready}, {31'b0, e.ar});
        check({e.nm, " b_ready"}, {31'b0, b_ready}, {31'b0, e.br});
      end else begin
        check({e.nm, " rf_rd"},   {27'b0, rf_rd}, {27'b0, e.rd});
        check({e.nm, " rf_data"}, rf_data,        e.data);
        check({e.nm, " busy"},    {16'b0, busy},  {16'b0, e.busy});
      end
    end
  end

  // One cycle of stimulus: expected readys this cycle, expected outputs next cycle.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic cv, input logic [4:0] crd, input logic r,
                      input logic ear, input logic ebr,
                      input logic [4:0] erd, input logic [31:0] edata, input logic [15:0] ebusy,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd; claim_valid = cv; claim_rd = crd;
    e = '{cyc: cyc, kind: 1'b0, ar: ear, br: ebr, rd: '0, data: '0, busy: '0, nm: nm};
    q.push_back(e);
    e = '{cyc: cyc + 1, kind: 1'b1, ar: 1'b0, br: 1'b0, rd: erd, data: edata, busy: ebusy, nm: nm};
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] edata, input logic [15:0] ebusy, input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, edata, ebusy, nm);
  endtask

  task automatic claim(input logic [4:0] crd, input logic [31:0] edata,
                       input logic [15:0] ebusy, input string nm);
    step(0, 0, 0, 0, 0, 0, 1, crd, 0, 0, 0, 5'd0, edata, ebusy, nm);
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0; claim_valid = 0; claim_rd = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h0, 16'h0, "reset0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h0, 16'h0, "reset1");

    // Single ALU writeback
    step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0, 5'd3, 32'hDEADBEEF, 16'h0, "a_alone");
    idle(32'hDEADBEEF, 16'h0, "a_alone_after");

    // Contention four cycles after reset: A,B,A,B
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h0, 16'h0, "reset2");
    idle(32'h0, 16'h0, "post_rst_idle1");
    idle(32'h0, 16'h0, "post_rst_idle2");
    idle(32'h0, 16'h0, "post_rst_idle3");
    step(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 0, 0, 1, 0, 5'd1, 32'h11111111, 16'h0, "rr_grant1_a");
    step(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 0, 0, 0, 1, 5'd2, 32'h22222222, 16'h0, "rr_grant2_b");
    step(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 0, 0, 1, 0, 5'd1, 32'h11111111, 16'h0, "rr_grant3_a");
    step(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 0, 0, 0, 1, 5'd2, 32'h22222222, 16'h0, "rr_grant4_b");
    idle(32'h22222222, 16'h0, "rr_after");

    // Claim x5, cleared by the load-unit write three cycles later
    claim(5'd5, 32'h22222222, 16'h0020, "claim5_c0");
    idle(32'h22222222, 16'h0020, "claim5_c1");
    idle(32'h22222222, 16'h0020, "claim5_c2");
    step(0, 0, 0, 1, 5'd5, 32'h00000055, 0, 0, 0, 0, 1, 5'd5, 32'h00000055, 16'h0020, "claim5_c3_b");
    idle(32'h00000055, 16'h0000, "claim5_c4");

    // Claim and clear of x7 on the same edge: claim wins
    step(1, 5'd7, 32'h00000077, 0, 0, 0, 1, 5'd7, 0, 1, 0, 5'd7, 32'h00000077, 16'h0080, "claim7_write7");
    claim(5'd7, 32'h00000077, 16'h0080, "claim7_vs_clear");
    idle(32'h00000077, 16'h0080, "claim7_hold");
    step(0, 0, 0, 1, 5'd7, 32'h00000070, 0, 0, 0, 0, 1, 5'd7, 32'h00000070, 16'h0080, "write7_b");
    idle(32'h00000070, 16'h0000, "clear7");

    // Dropped writes (x0, >=NREGS) and the top tracked register
    step(1, 5'd0,  32'h000000A0, 0, 0, 0, 1, 5'd0,  0, 1, 0, 5'd0,  32'h000000A0, 16'h0, "rd0_drop");
    step(1, 5'd20, 32'h00000A20, 0, 0, 0, 1, 5'd20, 0, 1, 0, 5'd0,  32'h00000A20, 16'h0, "rd20_drop");
    step(1, 5'd16, 32'h00000A16, 0, 0, 0, 1, 5'd16, 0, 1, 0, 5'd0,  32'h00000A16, 16'h0, "rd16_drop");
    step(1, 5'd15, 32'h00000F15, 0, 0, 0, 1, 5'd15, 0, 1, 0, 5'd15, 32'h00000F15, 16'h8000, "rd15_claim15");
    idle(32'h00000F15, 16'h0000, "clear15");

    // Pointer sits on B after the A-only transfers
    step(1, 5'd1, 32'h000000C1, 1, 5'd2, 32'h000000C2, 0, 0, 0, 0, 1, 5'd2, 32'h000000C2, 16'h0, "ptr_b_wins");

    // Reset with a write in flight and x4 busy
    claim(5'd4, 32'h000000C2, 16'h0010, "claim4");
    step(1, 5'd4, 32'h00000044, 0, 0, 0, 0, 0, 0, 1, 0, 5'd4, 32'h00000044, 16'h0010, "write4_a");
    step(1, 5'd1, 32'h00000001, 1, 5'd2, 32'h00000002, 1, 5'd9, 1, 0, 0, 5'd0, 32'h0, 16'h0, "reset_inflight");
    step(1, 5'd1, 32'h000000A1, 1, 5'd2, 32'h000000B2, 0, 0, 0, 1, 0, 5'd1, 32'h000000A1, 16'h0, "ptr_a_after_rst");
    idle(32'h000000A1, 16'h0, "final_idle");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
